// File: rtl/pwm_pkg.sv
// Shared constants and the duty-bus slicing helper for the multi-channel PWM block.
package pwm_pkg;

  localparam int unsigned CntWDef    = 32;
  localparam int unsigned CntWMax    = 64;
  localparam int unsigned MaxCh      = 16;
  localparam int unsigned DutyBusMax = MaxCh * CntWMax;

  // Returns channel `ch` of a packed duty bus whose fields are `cnt_w` bits wide.
  function automatic logic [CntWMax-1:0] duty_slice(input logic [DutyBusMax-1:0] bus,
                                                     input int unsigned          ch,
                                                     input int unsigned          cnt_w);
    logic [DutyBusMax-1:0] shifted;
    logic [CntWMax-1:0]    mask;
    shifted = bus >> (ch * cnt_w);
    mask    = '1;
    if (cnt_w < CntWMax) mask = mask >> (CntWMax - cnt_w);
    return shifted[CntWMax-1:0] & mask;
  endfunction

endpackage

// File: rtl/pwm_multi_if.sv
// Control/status bundle between the CSR bridge (master) and pwm_multi (slave).
// PWM_MULTI_PERIOD_IRQ_EN adds the o_period_tick status line.
interface pwm_multi_if #(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned CNT_W = pwm_pkg::CntWDef
);
  logic                  i_enable;
  logic [CNT_W-1:0]      i_period_in;
  logic [N_CH*CNT_W-1:0] i_duty_in;
  logic                  i_load;
  logic [N_CH-1:0]       o_pwm_out;
  logic                  o_upd_pending;
`ifdef PWM_MULTI_PERIOD_IRQ_EN
  logic                  o_period_tick;

  modport master (output i_enable, i_period_in, i_duty_in, i_load,
                  input  o_pwm_out, o_upd_pending, o_period_tick);
  modport slave  (input  i_enable, i_period_in, i_duty_in, i_load,
                  output o_pwm_out, o_upd_pending, o_period_tick);
`else
  modport master (output i_enable, i_period_in, i_duty_in, i_load,
                  input  o_pwm_out, o_upd_pending);
  modport slave  (input  i_enable, i_period_in, i_duty_in, i_load,
                  output o_pwm_out, o_upd_pending);
`endif
endinterface

// File: rtl/pwm_cmp_ch.sv
// One PWM channel: active duty register plus registered compare against the shared counter.
module pwm_cmp_ch
  import pwm_pkg::*;
#(
  parameter int unsigned CNT_W = CntWDef
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_run,
  input  logic             i_apply,
  input  logic [CNT_W-1:0] i_cnt,
  input  logic [CNT_W-1:0] i_duty_shadow,
  output logic             o_pwm
);

  logic [CNT_W-1:0] r_duty_act;
  logic             r_pwm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_duty_act <= '0;
      r_pwm      <= 1'b0;
    end else begin
      if (i_apply) r_duty_act <= i_duty_shadow;
      r_pwm <= i_run && (i_cnt < r_duty_act);
    end
  end

  assign o_pwm = r_pwm;

endmodule

// File: rtl/pwm_multi.sv
// N-channel PWM with a shared period counter and double-buffered period/duty updates.
// Optional PWM_MULTI_PERIOD_IRQ_EN adds a one-cycle period_tick after each terminal count.
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned CNT_W = CntWDef
) (
  input logic       clk,
  input logic       rst_n,
  pwm_multi_if.slave bus
);

  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      r_period_act;
  logic [CNT_W-1:0]      r_shadow_period;
  logic [N_CH*CNT_W-1:0] r_shadow_duty;
  logic                  r_pending;

  logic                  w_run;
  logic                  w_terminal;
  logic                  w_apply;
  logic [DutyBusMax-1:0] w_duty_ext;
  logic [N_CH-1:0]       w_pwm;

  assign w_run      = bus.i_enable && (r_period_act != '0);
  // Only meaningful while running, where period_act >= 1.
  assign w_terminal = r_cnt >= (r_period_act - CNT_W'(1));
  assign w_apply    = r_pending && (!w_run || w_terminal);
  assign w_duty_ext = DutyBusMax'(r_shadow_duty);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt           <= '0;
      r_period_act    <= '0;
      r_shadow_period <= '0;
      r_shadow_duty   <= '0;
      r_pending       <= 1'b0;
    end else begin
      if (bus.i_load) begin
        r_shadow_period <= bus.i_period_in;
        r_shadow_duty   <= bus.i_duty_in;
      end
      if (w_apply) r_period_act <= r_shadow_period;
      // A load coinciding with an apply keeps pending set for the newer shadow.
      r_pending <= bus.i_load || (r_pending && !w_apply);
      r_cnt     <= (w_run && !w_terminal) ? r_cnt + CNT_W'(1) : '0;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic [CNT_W-1:0] w_duty_shadow;
    assign w_duty_shadow = CNT_W'(duty_slice(w_duty_ext, g, CNT_W));

    pwm_cmp_ch #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_run        (w_run),
      .i_apply      (w_apply),
      .i_cnt        (r_cnt),
      .i_duty_shadow(w_duty_shadow),
      .o_pwm        (w_pwm[g])
    );
  end

  assign bus.o_pwm_out     = w_pwm;
  assign bus.o_upd_pending = r_pending;

`ifdef PWM_MULTI_PERIOD_IRQ_EN
  logic r_tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_tick <= 1'b0;
    else        r_tick <= w_run && w_terminal;
  end

  assign bus.o_period_tick = r_tick;
`endif

endmodule

// File: tb/tb_pwm_multi.sv
// Self-checking bench for pwm_multi: expected outputs are queued when stimulus is driven
// and popped for comparison one cycle later; PWM_MULTI_PERIOD_IRQ_EN also checks period_tick.
module tb_pwm_multi;
  import pwm_pkg::*;

  localparam int unsigned NCh  = 4;
  localparam int unsigned CntW = 16;

  typedef struct {
    logic [NCh-1:0] pwm;
    logic           pend;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  pwm_multi_if #(.N_CH(NCh), .CNT_W(CntW)) bus ();

  pwm_multi #(
    .N_CH (NCh),
    .CNT_W(CntW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cfg(input int unsigned period, input int unsigned d0, input int unsigned d1,
                           input int unsigned d2, input int unsigned d3);
    bus.i_period_in = CntW'(period);
    bus.i_duty_in   = {CntW'(d3), CntW'(d2), CntW'(d1), CntW'(d0)};
  endtask

  // Idle load followed by an idle edge that applies the shadow.
  task automatic configure(input int unsigned period, input int unsigned d0, input int unsigned d1,
                           input int unsigned d2, input int unsigned d3);
    bus.i_enable = 1'b0;
    drive_cfg(period, d0, d1, d2, d3);
    bus.i_load = 1'b1;
    tick();
    bus.i_load = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    exp_t e;
    rst_n = 1'b0;
    bus.i_enable = 1'b0;
    bus.i_load   = 1'b0;
    drive_cfg(0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      if (k == 2) rst_n = 1'b1;
      sb_q.push_back('{pwm: '0, pend: 1'b0});
      tick();
      e = sb_q.pop_front();
      n_checks++;
      if (bus.o_pwm_out !== e.pwm || bus.o_upd_pending !== e.pend)
        $display("FAIL reset k=%0d: pwm=%b pend=%b, want pwm=%b pend=%b",
                 k, bus.o_pwm_out, bus.o_upd_pending, e.pwm, e.pend);
      else n_pass++;
    end
`ifdef PWM_MULTI_PERIOD_IRQ_EN
    n_checks++;
    if (bus.o_period_tick !== 1'b0)
      $display("FAIL reset_tick: tick=%b, want 0", bus.o_period_tick);
    else n_pass++;
`endif
  endtask

  task automatic test_basic();
    exp_t        e;
    int unsigned duty[NCh] = '{0, 3, 10, 12};
    bus.i_enable = 1'b0;
    drive_cfg(10, 0, 3, 10, 12);
    for (int k = 0; k < 2; k++) begin
      bus.i_load = (k == 0);
      sb_q.push_back('{pwm: '0, pend: (k == 0)});
      tick();
      e = sb_q.pop_front();
      n_checks++;
      if (bus.o_pwm_out !== e.pwm || bus.o_upd_pending !== e.pend)
        $display("FAIL basic_load k=%0d: pwm=%b pend=%b, want pwm=%b pend=%b",
                 k, bus.o_pwm_out, bus.o_upd_pending, e.pwm, e.pend);
      else n_pass++;
    end
    bus.i_load   = 1'b0;
    bus.i_enable = 1'b1;
    for (int k = 0; k < 30; k++) begin
      for (int i = 0; i < NCh; i++) e.pwm[i] = (k % 10) < duty[i];
      e.pend = 1'b0;
      sb_q.push_back(e);
      tick();
      e = sb_q.pop_front();
      n_checks++;
      if (bus.o_pwm_out !== e.pwm || bus.o_upd_pending !== e.pend)
        $display("FAIL basic_run k=%0d: pwm=%b pend=%b, want pwm=%b pend=%b",
                 k, bus.o_pwm_out, bus.o_upd_pending, e.pwm, e.pend);
      else n_pass++;
    end
    bus.i_enable = 1'b0;
    sb_q.push_back('{pwm: '0, pend: 1'b0});
    tick();
    e = sb_q.pop_front();
    n_checks++;
    if (bus.o_pwm_out !== e.pwm)
      $display("FAIL basic_stop: pwm=%b, want %b", bus.o_pwm_out, e.pwm);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    exp_t        e;
    int unsigned duty[NCh] = '{0, 3, 10, 12};
    configure(10, 0, 3, 10, 12);
    bus.i_enable = 1'b1;
    tick();
    tick();
    drive_cfg(10, 1, 1, 1, 1);
    bus.i_load = 1'b1;
    sb_q.push_back('{pwm: 4'b1110, pend: 1'b1});
    tick();
    bus.i_load = 1'b0;
    e = sb_q.pop_front();
    n_checks++;
    if (bus.o_pwm_out !== e.pwm || bus.o_upd_pending !== e.pend)
      $display("FAIL reset_mid_pre: pwm=%b pend=%b, want pwm=%b pend=%b",
               bus.o_pwm_out, bus.o_upd_pending, e.pwm, e.pend);
    else n_pass++;
    #2;
    rst_n = 1'b0;
    sb_q.push_back('{pwm: '0, pend: 1'b0});
    #1;
    e = sb_q.pop_front();
    n_checks++;
    if (bus.o_pwm_out !== e.pwm || bus.o_upd_pending !== e.pend)
      $display("FAIL reset_mid_async: pwm=%b pend=%b, want pwm=%b pend=%b",
               bus.o_pwm_out, bus.o_upd_pending, e.pwm, e.pend);
    else n_pass++;
    rst_n = 1'b1;
    // Active period was cleared by reset, so reload with enable held high.
    drive_cfg(10, 0, 3, 10, 12);
    for (int k = 0; k < 12; k++) begin
      bus.i_load = (k == 0);
      if (k < 2) begin
        e.pwm  = '0;
        e.pend = (k == 0);
      end else begin
        for (int i = 0; i < NCh; i++) e.pwm[i] = (k - 2) < duty[i];
        e.pend = 1'b0;
      end
      sb_q.push_back(e);
      tick();
      e = sb_q.pop_front();
      n_checks++;
      if (bus.o_pwm_out !== e.pwm || bus.o_upd_pending !== e.pend)
        $display("FAIL reset_mid_restart k=%0d: pwm=%b pend=%b, want pwm=%b pend=%b",
                 k, bus.o_pwm_out, bus.o_upd_pending, e.pwm, e.pend);
      else n_pass++;
    end
  endtask

  task automatic test_glitch_free();
    exp_t e;
    configure(10, 5, 5, 5, 5);
    bus.i_enable = 1'b1;
    for (int j = 0; j < 20; j++) begin
      bus.i_load = (j == 3);
      if (j == 3) drive_cfg(10, 2, 2, 2, 2);
      e.pwm  = ((j < 10) ? (j < 5) : ((j - 10) < 2)) ? '1 : '0;
      e.pend = (j >= 3) && (j < 9);
      sb_q.push_back(e);
      tick();
      e = sb_q.pop_front();
      n_checks++;
      if (bus.o_pwm_out !== e.pwm || bus.o_upd_pending !== e.pend)
        $display("FAIL glitch_free j=%0d: pwm=%b pend=%b, want pwm=%b pend=%b",
                 j, bus.o_pwm_out, bus.o_upd_pending, e.pwm, e.pend);
      else n_pass++;
    end
    bus.i_load = 1'b0;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic hi;
    configure(10, 5, 5, 5, 5);
    bus.i_enable = 1'b1;
    for (int j = 0; j < 30; j++) begin
      bus.i_load = (j == 4) || (j == 9);
      if (j == 4) drive_cfg(10, 3, 3, 3, 3);
      if (j == 9) drive_cfg(10, 7, 7, 7, 7);
      if (j < 10)      hi = j < 5;
      else if (j < 20) hi = (j - 10) < 3;
      else             hi = (j - 20) < 7;
      e.pwm  = hi ? '1 : '0;
      e.pend = (j >= 4) && (j < 19);
      sb_q.push_back(e);
      tick();
      e = sb_q.pop_front();
      n_checks++;
      if (bus.o_pwm_out !== e.pwm || bus.o_upd_pending !== e.pend)
        $display("FAIL back_to_back j=%0d: pwm=%b pend=%b, want pwm=%b pend=%b",
                 j, bus.o_pwm_out, bus.o_upd_pending, e.pwm, e.pend);
      else n_pass++;
    end
    bus.i_load = 1'b0;
  endtask

  task automatic test_disable_edge();
    exp_t e;
    configure(10, 8, 8, 8, 8);
    bus.i_enable = 1'b1;
    for (int j = 0; j < 17; j++) begin
      // Drop enable with cnt at 6, then re-enable for a full period.
      bus.i_enable = (j != 6);
      if (j < 6)       e.pwm = '1;
      else if (j == 6) e.pwm = '0;
      else             e.pwm = ((j - 7) < 8) ? '1 : '0;
      e.pend = 1'b0;
      sb_q.push_back(e);
      tick();
      e = sb_q.pop_front();
      n_checks++;
      if (bus.o_pwm_out !== e.pwm || bus.o_upd_pending !== e.pend)
        $display("FAIL disable j=%0d: pwm=%b pend=%b, want pwm=%b pend=%b",
                 j, bus.o_pwm_out, bus.o_upd_pending, e.pwm, e.pend);
      else n_pass++;
    end
    configure(1, 0, 1, 1, 5);
    bus.i_enable = 1'b1;
    for (int j = 0; j < 5; j++) begin
      sb_q.push_back('{pwm: 4'b1110, pend: 1'b0});
      tick();
      e = sb_q.pop_front();
      n_checks++;
      if (bus.o_pwm_out !== e.pwm || bus.o_upd_pending !== e.pend)
        $display("FAIL period1 j=%0d: pwm=%b pend=%b, want pwm=%b pend=%b",
                 j, bus.o_pwm_out, bus.o_upd_pending, e.pwm, e.pend);
      else n_pass++;
    end
    configure(0, 3, 3, 3, 3);
    bus.i_enable = 1'b1;
    for (int j = 0; j < 5; j++) begin
      sb_q.push_back('{pwm: '0, pend: 1'b0});
      tick();
      e = sb_q.pop_front();
      n_checks++;
      if (bus.o_pwm_out !== e.pwm || bus.o_upd_pending !== e.pend)
        $display("FAIL period0 j=%0d: pwm=%b pend=%b, want pwm=%b pend=%b",
                 j, bus.o_pwm_out, bus.o_upd_pending, e.pwm, e.pend);
      else n_pass++;
    end
    bus.i_enable = 1'b0;
  endtask

`ifdef PWM_MULTI_PERIOD_IRQ_EN
  task automatic test_period_tick();
    logic tick_q[$];
    logic want;
    configure(8, 2, 2, 2, 2);
    bus.i_enable = 1'b1;
    for (int j = 0; j < 28; j++) begin
      if (j == 24) bus.i_enable = 1'b0;
      tick_q.push_back((j < 24) && ((j % 8) == 7));
      tick();
      want = tick_q.pop_front();
      n_checks++;
      if (bus.o_period_tick !== want)
        $display("FAIL period_tick j=%0d: tick=%b, want %b", j, bus.o_period_tick, want);
      else n_pass++;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_reset_mid();
    test_glitch_free();
    test_back_to_back();
    test_disable_edge();
`ifdef PWM_MULTI_PERIOD_IRQ_EN
    test_period_tick();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
